// File: rtl/axis_multi_channel_packer.sv
// axis_multi_channel_packer
// Collects NUM_CH AXI4-Stream slave channels into per-channel show-ahead FIFOs
// and emits fixed-length packets on one wide master stream.
//   mode 0 : forwards one selected channel, data left-justified in tdata
//   mode 1 : one beat from every channel per output word, ch0 in the MSBs
// A sticky status flag reports input framing (tlast) that disagrees with
// the programmed output packet length.
//
// Ports
//   clk, reset_n             clock, asynchronous active-low reset
//   s_axis_*                 per-channel slave streams (ch c at [c*IN_W +: IN_W])
//   m_axis_*                 packed master stream
//   cfg_mode/chan_sel/pkt_len  sampled only while the packet FSM is idle
//   status_clear             clears status_size_mismatch (a same-cycle set wins)
//   status_size_mismatch     sticky framing-mismatch flag
//
// FSM states
//   state  | meaning
//   IDLE   | latch config, clear beat counter, wait for all required FIFOs
//   ACTIVE | pop one entry per required FIFO per output beat until pkt_len beats

module axis_multi_channel_packer #(
  parameter int NUM_CH     = 2,
  parameter int IN_W       = 24,
  parameter int OUT_W      = 64,
  parameter int FIFO_DEPTH = 256,
  parameter int PKT_LEN_W  = 8,
  localparam int SEL_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [NUM_CH*IN_W-1:0] s_axis_tdata,
  input  logic [NUM_CH-1:0]      s_axis_tvalid,
  output logic [NUM_CH-1:0]      s_axis_tready,
  input  logic [NUM_CH-1:0]      s_axis_tlast,
  output logic [OUT_W-1:0]       m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic                   m_axis_tlast,
  input  logic                   cfg_mode,
  input  logic [SEL_W-1:0]       cfg_chan_sel,
  input  logic [PKT_LEN_W-1:0]   cfg_pkt_len,
  input  logic                   status_clear,
  output logic                   status_size_mismatch
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int PW = AW + 1;

  typedef enum logic {IDLE, ACTIVE} state_t;

  state_t                 state, state_nxt;
  logic [NUM_CH-1:0]      full, empty, pop, req_mask, head_last, popped_last;
  logic [NUM_CH*IN_W-1:0] head_data;
  logic                   run_q;
  logic                   mode_q, cur_mode;
  logic [SEL_W-1:0]       sel_q, live_sel, cur_sel;
  logic [PKT_LEN_W-1:0]   len_q, live_len, beat_cnt;
  logic                   req_ready, pop_en, last_beat, mismatch;
  logic [OUT_W-1:0]       pack_word;

  // Ready is held low during reset and until the first clock after release.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) run_q <= 1'b0;
    else          run_q <= 1'b1;
  end

  assign s_axis_tready = ~full & {NUM_CH{run_q}};

  // Per-channel FIFO. Entries become visible through a delayed copy of the
  // write pointer, so a push at edge t is poppable from edge t+2 on; full is
  // computed from the live pointer so back-pressure is immediate.
  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [IN_W:0]  mem [FIFO_DEPTH];
    logic [PW-1:0]  wr_ptr, wr_vis, rd_ptr;
    logic           push;

    assign push    = s_axis_tvalid[c] & s_axis_tready[c];
    assign full[c] = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign empty[c] = (wr_vis == rd_ptr);
    assign head_data[c*IN_W +: IN_W] = mem[rd_ptr[AW-1:0]][IN_W-1:0];
    assign head_last[c] = mem[rd_ptr[AW-1:0]][IN_W];

    always_ff @(posedge clk) begin
      if (push) mem[wr_ptr[AW-1:0]] <= {s_axis_tlast[c], s_axis_tdata[c*IN_W +: IN_W]};
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        wr_ptr <= '0;
        wr_vis <= '0;
        rd_ptr <= '0;
      end else begin
        if (push)   wr_ptr <= wr_ptr + PW'(1);
        wr_vis <= wr_ptr;
        if (pop[c]) rd_ptr <= rd_ptr + PW'(1);
      end
    end
  end

  always_comb begin
    live_sel = cfg_chan_sel;
    if (32'(cfg_chan_sel) >= 32'(NUM_CH)) live_sel = '0;
    live_len = (cfg_pkt_len == '0) ? PKT_LEN_W'(1) : cfg_pkt_len;
  end

  // In IDLE the live config decides whether to start; in ACTIVE the latched copy rules.
  assign cur_mode = (state == IDLE) ? cfg_mode : mode_q;
  assign cur_sel  = (state == IDLE) ? live_sel : sel_q;

  always_comb begin
    req_mask = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (cur_mode || (SEL_W'(c) == cur_sel)) req_mask[c] = 1'b1;
    end
  end

  assign req_ready = ((~empty & req_mask) == req_mask);
  assign last_beat = (beat_cnt == (len_q - PKT_LEN_W'(1)));
  assign pop       = {NUM_CH{pop_en}} & req_mask;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    pop_en    = 1'b0;
    case (state)
      IDLE: begin
        if (req_ready) state_nxt = ACTIVE;
      end
      ACTIVE: begin
        if (req_ready && (!m_axis_tvalid || m_axis_tready)) begin
          pop_en = 1'b1;
          if (last_beat) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mode_q   <= 1'b0;
      sel_q    <= '0;
      len_q    <= PKT_LEN_W'(1);
      beat_cnt <= '0;
    end else if (state == IDLE) begin
      mode_q   <= cfg_mode;
      sel_q    <= live_sel;
      len_q    <= live_len;
      beat_cnt <= '0;
    end else if (pop_en) begin
      beat_cnt <= beat_cnt + PKT_LEN_W'(1);
    end
  end

  always_comb begin
    pack_word = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (mode_q)
        pack_word[OUT_W-1-c*IN_W -: IN_W] = head_data[c*IN_W +: IN_W];
      else if (SEL_W'(c) == sel_q)
        pack_word[OUT_W-1 -: IN_W] = head_data[c*IN_W +: IN_W];
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end else if (pop_en) begin
      m_axis_tdata  <= pack_word;
      m_axis_tvalid <= 1'b1;
      m_axis_tlast  <= last_beat;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
    end
  end

  // Unequal tlast flags across channels always trip one of these two terms:
  // some flag is 1 on a non-last beat, or some flag is 0 on the last beat.
  assign popped_last = head_last & req_mask;
  assign mismatch = pop_en && ((!last_beat && (popped_last != '0)) ||
                               (last_beat && (popped_last != req_mask)));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) status_size_mismatch <= 1'b0;
    else          status_size_mismatch <= mismatch | (status_size_mismatch & ~status_clear);
  end

endmodule
